xy_input_conditioner: RTL and testbench

Front-end conditioning stage for the `x`/`y` control FSM. It takes two raw, asynchronous, possibly bouncing inputs (`x_raw`, `y_raw`) and produces clean, synchronous, debounced `x` and `y` levels. It aligns skewed transitions so both levels change on the same clock edge, and raises a one-cycle `chg` strobe whenever the presented pair changes. Its `x`/`y` outputs connect directly to the FSM's `x`/`y` inputs on the same `clk`/`rst`.

---
 rtl/xy_input_conditioner.sv | 131 +++++++++++++
 tb/tb_xy_input_conditioner.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/xy_input_conditioner.sv
// Conditions raw x/y inputs: synchronize, debounce, and merge skewed edges
// so both levels change on one clock edge, with a one-cycle chg strobe.
module xy_input_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int ALIGN_CYCLES    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic x_raw,
   input  logic y_raw,
   output logic x,
   output logic y,
   output logic chg
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = (ALIGN_CYCLES > 1) ? $clog2(ALIGN_CYCLES) : 1;
   localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TLAST =
      TW'((ALIGN_CYCLES > 0) ? ALIGN_CYCLES - 1 : 0);
   localparam bit ALIGN_EN = (ALIGN_CYCLES > 0);

   typedef enum logic {
      IDLE  = 1'b0,
      ALIGN = 1'b1
   } state_t;

   logic [1:0] raw;
   logic [1:0] s;
   logic [1:0] db;

   assign raw = {y_raw, x_raw};

   // Channel 0 is x, channel 1 is y.
   for (genvar c = 0; c < 2; c++) begin : g_ch
      logic [SYNC_STAGES-1:0] sq;
      logic [CW-1:0]          cq;
      logic                   dq;

      always_ff @(posedge clk) begin
         if (rst) begin
            sq <= '0;
            cq <= '0;
            dq <= 1'b0;
         end else begin
            sq <= {sq[SYNC_STAGES-2:0], raw[c]};
            if (sq[SYNC_STAGES-1] == dq) begin
               cq <= '0;
            end else if (cq == CLAST) begin
               dq <= sq[SYNC_STAGES-1];
               cq <= '0;
            end else begin
               cq <= cq + CW'(1);
            end
         end
      end

      assign s[c]  = sq[SYNC_STAGES-1];
      assign db[c] = dq;
   end

   state_t          state_q;
   state_t          state_d;
   logic [TW-1:0]   timer_q;
   logic [TW-1:0]   timer_d;
   logic            x_d;
   logic            y_d;
   logic            chg_d;
   logic            commit;
   logic            differs;

   assign differs = (db != {y, x});

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      x_d     = x;
      y_d     = y;
      chg_d   = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (differs) begin
               if (!ALIGN_EN) begin
                  commit = 1'b1;
               end else begin
                  state_d = ALIGN;
                  timer_d = '0;
               end
            end
         end
         ALIGN: begin
            // Late db flips are absorbed; commit samples db as it is now.
            if (timer_q == TLAST) begin
               commit  = 1'b1;
               state_d = IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
      if (commit) begin
         x_d   = db[0];
         y_d   = db[1];
         chg_d = differs;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         x       <= 1'b0;
         y       <= 1'b0;
         chg     <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         x       <= x_d;
         y       <= y_d;
         chg     <= chg_d;
      end
   end

endmodule

// File: tb/tb_xy_input_conditioner.sv
// Directed bench for xy_input_conditioner: default instance plus a
// fast instance with no align window and single-cycle debounce.
module tb_xy_input_conditioner;

   logic clk = 1'b0;
   logic rst;
   logic x_raw, y_raw;
   logic x, y, chg;
   logic x2_raw, y2_raw;
   logic x2, y2, chg2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   xy_input_conditioner dut (
      .clk  (clk),
      .rst  (rst),
      .x_raw(x_raw),
      .y_raw(y_raw),
      .x    (x),
      .y    (y),
      .chg  (chg)
   );

   xy_input_conditioner #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(1),
      .ALIGN_CYCLES   (0)
   ) dut_fast (
      .clk  (clk),
      .rst  (rst),
      .x_raw(x2_raw),
      .y_raw(y2_raw),
      .x    (x2),
      .y    (y2),
      .chg  (chg2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, logic [2:0] obs, logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance n edges, checking {x,y,chg} of the chosen instance each edge.
   task automatic run(string tag, int n, logic [2:0] exp, bit fast);
      for (int i = 0; i < n; i++) begin
         tick();
         if (fast) check(tag, {x2, y2, chg2}, exp);
         else      check(tag, {x, y, chg}, exp);
      end
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      x_raw  = 1'b0;
      y_raw  = 1'b0;
      x2_raw = 1'b0;
      y2_raw = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      x_raw  = 1'b1;
      y_raw  = 1'b1;
      x2_raw = 1'b0;
      y2_raw = 1'b0;

      // Reset with raw inputs already high
      run("rst_hold", 3, 3'b000, 1'b0);
      rst = 1'b0;
      run("rst_rel_wait", 22, 3'b000, 1'b0);
      run("rst_rel_e23", 1, 3'b111, 1'b0);
      run("rst_rel_after", 3, 3'b110, 1'b0);

      // Single clean change on x
      do_reset();
      x_raw = 1'b1;
      run("single_wait", 22, 3'b000, 1'b0);
      run("single_e23", 1, 3'b101, 1'b0);
      run("single_after", 5, 3'b100, 1'b0);

      // Bounce rejection: 10 and 15 cycle pulses, then a real hold
      do_reset();
      x_raw = 1'b1;
      run("bounce10_hi", 10, 3'b000, 1'b0);
      x_raw = 1'b0;
      run("bounce10_lo", 30, 3'b000, 1'b0);
      x_raw = 1'b1;
      run("bounce15_hi", 15, 3'b000, 1'b0);
      x_raw = 1'b0;
      run("bounce15_lo", 30, 3'b000, 1'b0);
      x_raw = 1'b1;
      run("bounce_hold_wait", 22, 3'b000, 1'b0);
      run("bounce_hold_e23", 1, 3'b101, 1'b0);
      run("bounce_hold_after", 3, 3'b100, 1'b0);

      // Skew of 4 merges into one commit
      do_reset();
      x_raw = 1'b1;
      run("skew4_pre", 4, 3'b000, 1'b0);
      y_raw = 1'b1;
      run("skew4_wait", 18, 3'b000, 1'b0);
      run("skew4_e23", 1, 3'b111, 1'b0);
      run("skew4_after", 4, 3'b110, 1'b0);

      // Skew of 5 splits into two commits
      do_reset();
      x_raw = 1'b1;
      run("skew5_pre", 5, 3'b000, 1'b0);
      y_raw = 1'b1;
      run("skew5_wait", 17, 3'b000, 1'b0);
      run("skew5_e23", 1, 3'b101, 1'b0);
      run("skew5_gap", 4, 3'b100, 1'b0);
      run("skew5_e28", 1, 3'b111, 1'b0);
      run("skew5_after", 3, 3'b110, 1'b0);

      // Reset while ALIGN is pending
      do_reset();
      x_raw = 1'b1;
      run("midrst_wait", 19, 3'b000, 1'b0);
      rst = 1'b1;
      run("midrst_e20", 1, 3'b000, 1'b0);
      rst = 1'b0;
      run("midrst_no_commit", 22, 3'b000, 1'b0);
      run("midrst_relaunch", 1, 3'b101, 1'b0);
      run("midrst_after", 2, 3'b100, 1'b0);

      // Fast instance: single channel, then simultaneous rise
      do_reset();
      x2_raw = 1'b1;
      run("fast_x_wait", 3, 3'b000, 1'b1);
      run("fast_x_e4", 1, 3'b101, 1'b1);
      run("fast_x_after", 3, 3'b100, 1'b1);

      do_reset();
      x2_raw = 1'b1;
      y2_raw = 1'b1;
      run("fast_xy_wait", 3, 3'b000, 1'b1);
      run("fast_xy_e4", 1, 3'b111, 1'b1);
      run("fast_xy_after", 3, 3'b110, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
